// File: rtl/dram_ctrl.sv
// Page-mode RAS/CAS initiator: turns single-word valid/ready requests into DRAM pin
// sequences, keeps the last row open, and returns a one-cycle response pulse.
module dram_ctrl #(
  parameter int unsigned ROW_W = 12,
  parameter int unsigned COL_W = 10,
  parameter int unsigned T_RP  = 2,
  parameter int unsigned T_RCD = 1,
  parameter int unsigned CL    = 1
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ROW_W+COL_W-1:0] req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [3:0]             req_wstrb,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   CSn,
  output logic                   RASn,
  output logic                   CASn,
  output logic [3:0]             WEn,
  output logic [ROW_W-1:0]       A,
  output logic [31:0]            D,
  input  logic [31:0]            Q
);

  typedef enum logic [2:0] {
    StIdle,
    StOpen,
    StPre,
    StRow,
    StAct,
    StCol,
    StCas
  } state_e;

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] RpLast  = CntW'(T_RP - 1);
  localparam logic [CntW-1:0] RcdLast = CntW'(T_RCD - 1);
  localparam logic [CntW-1:0] ClLast  = CntW'(CL - 1);

  state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0] open_row_q, open_row_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             write_q, write_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;

  // All pin-side outputs are registered so the DRAM sees glitch-free levels.
  logic             csn_q, csn_d;
  logic             rasn_q, rasn_d;
  logic             casn_q, casn_d;
  logic [3:0]       wen_q, wen_d;
  logic [ROW_W-1:0] a_q, a_d;
  logic [31:0]      d_q, d_d;
  logic             ready_q, ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             accept;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;

  assign accept  = req_valid & ready_q;
  assign req_row = req_addr[ROW_W+COL_W-1:COL_W];
  assign req_col = req_addr[COL_W-1:0];

  // State register.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and request capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    open_row_d = open_row_q;
    row_d      = row_q;
    col_d      = col_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;

    if (accept) begin
      row_d   = req_row;
      col_d   = req_col;
      write_d = req_write;
      wdata_d = req_wdata;
      wstrb_d = req_wstrb;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StRow;
      end
      StOpen: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = (req_row == open_row_q) ? StCol : StPre;
        end
      end
      StPre: begin
        if (cnt_q == RpLast) begin
          state_d = StRow;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRow: begin
        cnt_d   = '0;
        state_d = StAct;
      end
      StAct: begin
        open_row_d = row_q;
        if (cnt_q == RcdLast) begin
          state_d = StCol;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCol: begin
        cnt_d   = '0;
        state_d = StCas;
      end
      StCas: begin
        if (write_q || (cnt_q == ClLast)) begin
          state_d = StOpen;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pin and response values for the cycle we are about to enter.
  always_comb begin
    csn_d        = 1'b0;
    rasn_d       = 1'b1;
    casn_d       = 1'b1;
    wen_d        = 4'hF;
    a_d          = a_q;
    d_d          = d_q;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;

    unique case (state_d)
      StIdle: begin
        a_d     = '0;
        ready_d = 1'b1;
      end
      StOpen: begin
        rasn_d  = 1'b0;
        ready_d = 1'b1;
      end
      StPre: ;
      StRow: a_d = row_d;
      StAct: begin
        rasn_d = 1'b0;
        a_d    = row_d;
      end
      StCol: begin
        rasn_d             = 1'b0;
        a_d                = '0;
        a_d[COL_W-1:0]     = col_d;
        d_d                = wdata_d;
        wen_d              = write_d ? ~wstrb_d : 4'hF;
      end
      StCas: begin
        rasn_d = 1'b0;
        casn_d = 1'b0;
        wen_d  = wen_q;
      end
      default: ;
    endcase

    // Leaving CAS completes the access; a read captures Q on that same edge.
    if (state_q == StCas && state_d == StOpen) begin
      resp_valid_d = 1'b1;
      if (!write_q) rdata_d = Q;
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      cnt_q        <= '0;
      open_row_q   <= '0;
      row_q        <= '0;
      col_q        <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      csn_q        <= 1'b1;
      rasn_q       <= 1'b1;
      casn_q       <= 1'b1;
      wen_q        <= 4'hF;
      a_q          <= '0;
      d_q          <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      cnt_q        <= cnt_d;
      open_row_q   <= open_row_d;
      row_q        <= row_d;
      col_q        <= col_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      csn_q        <= csn_d;
      rasn_q       <= rasn_d;
      casn_q       <= casn_d;
      wen_q        <= wen_d;
      a_q          <= a_d;
      d_q          <= d_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign CSn        = csn_q;
  assign RASn       = rasn_q;
  assign CASn       = casn_q;
  assign WEn        = wen_q;
  assign A          = a_q;
  assign D          = d_q;
  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: a pin-level DRAM model answers the controller, and a
// request-level reference predicts latency and data from the page-mode rules.
module tb_dram_ctrl;
  localparam int ROW_W = 12;
  localparam int COL_W = 10;
  localparam int T_RP  = 2;
  localparam int T_RCD = 1;
  localparam int CL    = 1;

  logic                   CK, RST;
  logic                   req_valid, req_ready, req_write;
  logic [ROW_W+COL_W-1:0] req_addr;
  logic [31:0]            req_wdata;
  logic [3:0]             req_wstrb;
  logic                   resp_valid;
  logic [31:0]            resp_rdata;
  logic                   CSn, RASn, CASn;
  logic [3:0]             WEn;
  logic [ROW_W-1:0]       A;
  logic [31:0]            D, Q;

  int vectors = 0;
  int errors  = 0;

  dram_ctrl #(
    .ROW_W(ROW_W), .COL_W(COL_W), .T_RP(T_RP), .T_RCD(T_RCD), .CL(CL)
  ) dut (
    .CK(CK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .CSn(CSn), .RASn(RASn), .CASn(CASn), .WEn(WEn), .A(A), .D(D), .Q(Q)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Pin-level DRAM: latch row on RASn falling, read/write on CASn low.
  logic [31:0] pin_mem [int];
  int          pin_row = 0;
  logic        ras_prev = 1'b1;
  int          pin_key;
  logic [31:0] pin_word;

  always @(negedge CK) begin
    if (RST) begin
      ras_prev = 1'b1;
    end else begin
      if (!RASn && ras_prev) pin_row = int'(A);
      ras_prev = RASn;
      if (!CASn && !CSn) begin
        pin_key  = pin_row * (1 << COL_W) + int'(A[COL_W-1:0]);
        pin_word = pin_mem.exists(pin_key) ? pin_mem[pin_key] : 32'h0;
        for (int b = 0; b < 4; b++) if (!WEn[b]) pin_word[b*8 +: 8] = D[b*8 +: 8];
        if (WEn != 4'hF) pin_mem[pin_key] = pin_word;
        Q <= pin_word;
      end
    end
  end

  // Request-level reference model.
  logic [31:0] ref_mem [int];
  bit          ref_row_open = 0;
  int          ref_open_row = 0;

  function automatic int exp_latency(input bit wr, input int row);
    int lat = wr ? 3 : 2 + CL;
    if (!ref_row_open) lat += 1 + T_RCD;
    else if (row != ref_open_row) lat += T_RP + 1 + T_RCD;
    return lat;
  endfunction

  function automatic logic [31:0] ref_read(input int key);
    return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
  endfunction

  function automatic logic [31:0] pin_read(input int key);
    return pin_mem.exists(key) ? pin_mem[key] : 32'h0;
  endfunction

  task automatic ref_apply(input bit wr, input int row, input int col,
                           input logic [31:0] wd, input logic [3:0] ws);
    int key = row * (1 << COL_W) + col;
    logic [31:0] w = ref_read(key);
    if (wr) begin
      for (int b = 0; b < 4; b++) if (ws[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      ref_mem[key] = w;
    end
    ref_row_open = 1;
    ref_open_row = row;
  endtask

  // Pin observations gathered while a request is in flight.
  int               obs_ras_high;
  logic [ROW_W-1:0] obs_ras_fall_a, obs_cas_a;
  logic [3:0]       obs_cas_wen;

  // Called at a negedge; returns at the negedge where resp_valid is seen.
  task automatic drive_req(input bit wr, input int row, input int col, input logic [31:0] wd,
                           input logic [3:0] ws, output int lat, output logic [31:0] rd,
                           output bit ok);
    logic prev_ras = RASn;
    int w = 0;
    ok  = 0;
    lat = 0;
    rd  = 'x;
    obs_ras_high   = 0;
    obs_ras_fall_a = 'x;
    obs_cas_a      = 'x;
    obs_cas_wen    = 4'hF;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = {ROW_W'(row), COL_W'(col)};
    req_wdata = wd;
    req_wstrb = ws;
    while (!req_ready && w < 50) begin
      @(negedge CK);
      w++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge CK);
    #1;
    req_valid = 1'b0;
    req_addr  = ($urandom & 32'h3F_FFFF);
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    req_write = 1'($urandom);
    for (int c = 0; c < 40; c++) begin
      @(negedge CK);
      lat++;
      if (RASn) obs_ras_high++;
      if (!RASn && prev_ras) obs_ras_fall_a = A;
      prev_ras = RASn;
      if (!CASn) begin
        obs_cas_a   = A;
        obs_cas_wen = WEn;
      end
      if (resp_valid) begin
        ok = 1;
        rd = resp_rdata;
        break;
      end
    end
  endtask

  localparam logic [84:0] RESET_VEC = {1'b1, 1'b1, 1'b1, 4'hF, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0};

  task automatic test_reset();
    logic [84:0] v;
    RST = 1'b1;
    repeat (2) @(posedge CK);
    @(negedge CK);
    v = {CSn, RASn, CASn, WEn, A, D, req_ready, resp_valid, resp_rdata};
    vectors++;
    if (v !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", v, RESET_VEC);
    end
    #2 RST = 1'b0;
    @(negedge CK);
    vectors++;
    if (CSn !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_csn: got %b expected 0", CSn);
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
    ref_row_open = 0;
  endtask

  task automatic test_idle_write();
    int lat, el;
    logic [31:0] rd;
    bit ok;
    el = exp_latency(1, 5);
    drive_req(1, 5, 10, 32'd10, 4'hF, lat, rd, ok);
    ref_apply(1, 5, 10, 32'd10, 4'hF);
    vectors++;
    if (!ok || lat != el) begin
      errors++;
      $display("FAIL idle_write_latency: got %0d (resp %0b) expected %0d", lat, ok, el);
    end
    vectors++;
    if (obs_ras_fall_a !== 12'd5) begin
      errors++;
      $display("FAIL idle_write_row_addr: got %0d expected 5", obs_ras_fall_a);
    end
    vectors++;
    if (obs_cas_a !== 12'd10 || obs_cas_wen !== 4'h0) begin
      errors++;
      $display("FAIL idle_write_cas: got A=%0d WEn=%h expected A=10 WEn=0", obs_cas_a, obs_cas_wen);
    end
    vectors++;
    if (pin_read(5130) !== ref_read(5130)) begin
      errors++;
      $display("FAIL idle_write_mem: got %h expected %h", pin_read(5130), ref_read(5130));
    end
  endtask

  task automatic test_page_hit_write();
    int lat, el;
    logic [31:0] rd;
    bit ok;
    el = exp_latency(1, 5);
    drive_req(1, 5, 11, 32'd11, 4'hF, lat, rd, ok);
    ref_apply(1, 5, 11, 32'd11, 4'hF);
    vectors++;
    if (!ok || lat != el || obs_ras_high != 0) begin
      errors++;
      $display("FAIL hit_write: got lat=%0d ras_high=%0d expected lat=%0d ras_high=0",
               lat, obs_ras_high, el);
    end
    vectors++;
    if (pin_read(5131) !== 32'h0000_000B) begin
      errors++;
      $display("FAIL hit_write_mem: got %h expected 0000000b", pin_read(5131));
    end
  endtask

  task automatic test_page_hit_reads();
    int lat, el;
    logic [31:0] rd;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      el = exp_latency(0, 5);
      drive_req(0, 5, 10 + i, 32'h0, 4'h0, lat, rd, ok);
      vectors++;
      if (!ok || lat != el || obs_ras_high != 0 || rd !== ref_read(5130 + i)) begin
        errors++;
        $display("FAIL hit_read_%0d: got lat=%0d ras_high=%0d data=%h expected lat=%0d data=%h",
                 i, lat, obs_ras_high, rd, el, ref_read(5130 + i));
      end
      ref_apply(0, 5, 10 + i, 32'h0, 4'h0);
    end
  endtask

  task automatic test_page_miss_read();
    int lat, el;
    logic [31:0] rd;
    bit ok;
    pin_mem[6144] = 32'hDEAD_BEEF;
    ref_mem[6144] = 32'hDEAD_BEEF;
    el = exp_latency(0, 6);
    drive_req(0, 6, 0, 32'h0, 4'h0, lat, rd, ok);
    ref_apply(0, 6, 0, 32'h0, 4'h0);
    vectors++;
    if (!ok || lat != el || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL miss_read: got lat=%0d data=%h expected lat=%0d data=deadbeef", lat, rd, el);
    end
    vectors++;
    if (obs_ras_high != T_RP + 1 || obs_ras_fall_a !== 12'd6) begin
      errors++;
      $display("FAIL miss_read_ras: got high=%0d row=%0d expected high=%0d row=6",
               obs_ras_high, obs_ras_fall_a, T_RP + 1);
    end
    @(negedge CK);
    vectors++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL resp_pulse_width: got %b expected 0", resp_valid);
    end
  endtask

  task automatic test_partial_write();
    int lat, el;
    logic [31:0] rd;
    bit ok;
    pin_mem[7171] = 32'hAABB_CCDD;
    ref_mem[7171] = 32'hAABB_CCDD;
    el = exp_latency(1, 7);
    drive_req(1, 7, 3, 32'h1122_3344, 4'b0101, lat, rd, ok);
    ref_apply(1, 7, 3, 32'h1122_3344, 4'b0101);
    vectors++;
    if (!ok || lat != el || obs_cas_wen !== 4'b1010) begin
      errors++;
      $display("FAIL partial_write: got lat=%0d WEn=%b expected lat=%0d WEn=1010",
               lat, obs_cas_wen, el);
    end
    el = exp_latency(0, 7);
    drive_req(0, 7, 3, 32'h0, 4'h0, lat, rd, ok);
    vectors++;
    if (!ok || lat != el || rd !== 32'hAA22_CC44) begin
      errors++;
      $display("FAIL partial_readback: got lat=%0d data=%h expected lat=%0d data=aa22cc44",
               lat, rd, el);
    end
  endtask

  task automatic test_reset_mid_sequence();
    logic [84:0] v;
    logic prev_ras;
    bit found = 0;
    bit spurious = 0;
    int lat, el;
    logic [31:0] rd;
    bit ok;
    prev_ras = RASn;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = {12'd9, 10'd4};
    @(posedge CK);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge CK);
      if (!RASn && prev_ras) found = 1;
      prev_ras = RASn;
    end
    vectors++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_reach_act: got no ACT within 20 cycles expected ACT");
    end
    RST = 1'b1;
    #1;
    v = {CSn, RASn, CASn, WEn, A, D, req_ready, resp_valid, resp_rdata};
    vectors++;
    if (v !== RESET_VEC) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h expected %h", v, RESET_VEC);
    end
    ref_row_open = 0;
    repeat (2) @(negedge CK);
    RST = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CK);
      if (resp_valid) spurious = 1;
    end
    vectors++;
    if (spurious) begin
      errors++;
      $display("FAIL mid_reset_no_resp: got resp_valid=1 expected 0");
    end
    el = exp_latency(1, 9);
    drive_req(1, 9, 1, 32'h5A5A_0001, 4'hF, lat, rd, ok);
    ref_apply(1, 9, 1, 32'h5A5A_0001, 4'hF);
    vectors++;
    if (!ok || lat != el) begin
      errors++;
      $display("FAIL after_reset_from_idle: got lat=%0d expected %0d", lat, el);
    end
  endtask

  task automatic test_random();
    int rows[4] = '{5, 6, 7, 0};
    int lat, el, row, col, key;
    logic [31:0] rd, wd;
    logic [3:0] ws;
    bit wr, ok;
    rows[3] = int'($urandom_range(0, 4095));
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CK);
      wr  = 1'($urandom_range(0, 1));
      row = rows[$urandom_range(0, 3)];
      col = int'($urandom_range(0, 15));
      wd  = $urandom;
      ws  = 4'($urandom_range(0, 15));
      key = row * (1 << COL_W) + col;
      el  = exp_latency(wr, row);
      drive_req(wr, row, col, wd, ws, lat, rd, ok);
      vectors++;
      if (!ok || lat != el || (!wr && rd !== ref_read(key))) begin
        errors++;
        $display("FAIL random_%0d: got lat=%0d data=%h expected lat=%0d data=%h (wr=%0b)",
                 i, lat, rd, el, wr ? 32'h0 : ref_read(key), wr);
      end
      ref_apply(wr, row, col, wd, ws);
    end
    foreach (ref_mem[k]) begin
      vectors++;
      if (pin_read(k) !== ref_mem[k]) begin
        errors++;
        $display("FAIL mem_word_%0d: got %h expected %h", k, pin_read(k), ref_mem[k]);
      end
    end
  endtask

  initial begin
    RST       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    Q         = '0;
    test_reset();
    test_idle_write();
    test_page_hit_write();
    test_page_hit_reads();
    test_page_miss_read();
    test_partial_write();
    test_reset_mid_sequence();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
